instr_fetch_unit: RTL

//  Produces the instruction stream that feeds the control-unit decoder (the upstream end of the decode interface).

---
 rtl/instr_fetch_unit_pkg.sv | 25 ++
 rtl/instr_fetch_unit_if.sv | 31 +++
 rtl/instr_fetch_unit_fifo.sv | 55 +++++
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode definitions: data width, NOP encoding, fetch buffer entry
// and the 5-bit major opcodes (instr[6:2]) the decoder switches on.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam logic [4:0] OPCODE_LOAD     = 5'b00000;
  localparam logic [4:0] OPCODE_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPCODE_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC    = 5'b00101;
  localparam logic [4:0] OPCODE_STORE    = 5'b01000;
  localparam logic [4:0] OPCODE_OP       = 5'b01100;
  localparam logic [4:0] OPCODE_LUI      = 5'b01101;
  localparam logic [4:0] OPCODE_BRANCH   = 5'b11000;
  localparam logic [4:0] OPCODE_JALR     = 5'b11001;
  localparam logic [4:0] OPCODE_JAL      = 5'b11011;
  localparam logic [4:0] OPCODE_SYSTEM   = 5'b11100;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response, decode handshake and
// execute redirect. master = fetch unit, slave = memory/decode/execute side.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_illegal;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_illegal,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, if_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_illegal,
    output imem_req_ready, imem_rsp_valid, imem_rdata, if_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO (power-of-2 depth) with flush; push while full is
// accepted only when a pop frees the slot in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, credit-limited in-order imem reads, buffered
// {pc,instr} stream to decode, redirect with stale-response discard.
// Optional macro FETCH_ILLEGAL_CHECK_EN enables the non-32-bit instruction flag.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     inflight;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pcq_empty;
  logic            pcq_full;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  always_comb begin
    inflight  = {1'b0, fifo_count} + {1'b0, outstanding};
    credit_ok = (inflight < (CW+1)'(FIFO_DEPTH)) && !pcq_full;
  end

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit_ok;
  assign bus.imem_addr      = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep           = bus.imem_rsp_valid && !pcq_empty && (discard == '0)
                              && !bus.redirect_valid;
  assign pop                = !fifo_empty && bus.if_ready;
  assign push_entry         = '{pc: rsp_pc, instr: bus.imem_rdata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // The pc queue holds one entry per in-flight request, so its occupancy is
  // the outstanding count. It is never flushed: stale responses still pop it.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (logic [XLEN-1:0])
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (bus.imem_rsp_valid),
    .head      (rsp_pc),
    .empty     (pcq_empty),
    .full      (pcq_full),
    .count     (outstanding)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ~XLEN'(3);
      discard  <= outstanding - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (bus.imem_rsp_valid && (discard != '0)) begin
        discard <= discard - 1'b1;
      end
    end
  end

  always_comb begin
    bus.if_valid = !fifo_empty;
    bus.if_instr = fifo_empty ? NOP_INSTR : head.instr;
    bus.if_pc    = fifo_empty ? '0 : head.pc;
  end

`ifdef FETCH_ILLEGAL_CHECK_EN
  assign bus.if_illegal = !fifo_empty && (head.instr[1:0] != 2'b11);
`else
  assign bus.if_illegal = 1'b0;
`endif

  a_no_live_drop : assert property (@(posedge clk) disable iff (rst)
    !(rsp_keep && fifo_full && !pop));

endmodule
